led_div_ctrl: RTL and testbench

//   Pushbutton front end for the LED counter. Synchronises and debounces two buttons (up/down).

---
 rtl/led_div_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_led_div_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_div_ctrl.sv
// -----------------------------------------------------------------------------
// led_div_ctrl
//   Pushbutton front end for the LED counter. Two raw buttons (up / down) are
//   synchronised, debounced and turned into press / auto-repeat events that
//   step a saturating 5-bit divisor. Every real change of the divisor is
//   flagged by a one-cycle write strobe, so the LED counter can latch div_o
//   on wren_o directly.
//
// Ports
//   clk100    in   1  100 MHz clock
//   rstn      in   1  asynchronous active-low reset (release must be clock-synchronous)
//   btn_up_i  in   1  raw up button, asynchronous, active high
//   btn_dn_i  in   1  raw down button, asynchronous, active high
//   div_o     out  5  current divisor (LED counter div input)
//   wren_o    out  1  high exactly in the first cycle div_o shows a new value
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// led_div_btn
//   One button channel: 2-flop synchroniser, counter debouncer and the
//   press / auto-repeat event generator.
//
// Ports
//   clk100  in   1  clock
//   rstn    in   1  asynchronous active-low reset
//   btn_i   in   1  raw button level
//   ev_o    out  1  one-cycle event: press (db rising) or auto-repeat
// -----------------------------------------------------------------------------
module led_div_btn #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 20_000_000
) (
  input  logic clk100,
  input  logic rstn,
  input  logic btn_i,
  output logic ev_o
);

  // Debounce counter only has to reach DEBOUNCE_CYC-1.
  localparam int DCNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST =
    DCNT_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);

  // Repeat counter spans the longer of the two intervals and parks at its
  // top value instead of wrapping (relevant when auto-repeat is disabled).
  localparam int RCNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RCNT_W   = (RCNT_MAX > 0) ? $clog2(RCNT_MAX + 1) : 1;
  localparam logic [RCNT_W-1:0] RCNT_TOP  = RCNT_W'(RCNT_MAX);
  localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam bit RPT_EN = (REPEAT_CYC != 0);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              db_q, db_d;
  logic              db_prev_q, db_prev_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rep_q, rep_d;     // first auto-repeat of this hold already fired
  logic              press;
  logic              rpt_ev;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      rep_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      rep_q     <= rep_d;
    end
  end

  // Synchroniser and debouncer. Any sample agreeing with the accepted level
  // restarts the stability count, so a bounce back always clears dcnt.
  always_comb begin
    s1_d      = btn_i;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    dcnt_d    = dcnt_q;
    if (s2_q == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      db_d   = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  assign press = db_q & ~db_prev_q;

  // rcnt holds 0 in the event cycle, so the first repeat lands HOLD_CYC
  // cycles after the press and later ones REPEAT_CYC cycles apart.
  always_comb begin
    rpt_ev = 1'b0;
    if (RPT_EN && db_q && !press)
      rpt_ev = rep_q ? (rcnt_q == REP_LAST) : (rcnt_q == HOLD_LAST);

    rcnt_d = rcnt_q;
    if (!db_q || press || rpt_ev)
      rcnt_d = '0;
    else if (rcnt_q != RCNT_TOP)
      rcnt_d = rcnt_q + RCNT_W'(1);

    rep_d = rep_q;
    if (!db_q || press)
      rep_d = 1'b0;
    else if (rpt_ev)
      rep_d = 1'b1;
  end

  assign ev_o = press | rpt_ev;

endmodule

module led_div_ctrl #(
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter int         HOLD_CYC     = 50_000_000,
  parameter int         REPEAT_CYC   = 20_000_000,
  parameter logic [4:0] DIV_INIT     = 5'd1,
  parameter logic [4:0] DIV_MIN      = 5'd0,
  parameter logic [4:0] DIV_MAX      = 5'd31
) (
  input  logic       clk100,
  input  logic       rstn,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [4:0] div_o,
  output logic       wren_o
);

  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] btn_raw;   // [0] = up, [1] = down
  logic [NUM_BTN-1:0] ev;
  logic [4:0]         div_q, div_d;
  logic               wren_q, wren_d;

  assign btn_raw = {btn_dn_i, btn_up_i};

  led_div_btn #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_btn [NUM_BTN-1:0] (
    .clk100 (clk100),
    .rstn   (rstn),
    .btn_i  (btn_raw),
    .ev_o   (ev)
  );

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      div_q  <= DIV_INIT;
      wren_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wren_q <= wren_d;
    end
  end

  // Simultaneous up and down events cancel. The strobe follows the value:
  // a saturated step leaves div untouched and raises no strobe.
  always_comb begin
    div_d  = div_q;
    wren_d = 1'b0;
    unique case (ev)
      2'b01: begin
        if (div_q < DIV_MAX) begin
          div_d  = div_q + 5'd1;
          wren_d = 1'b1;
        end
      end
      2'b10: begin
        if (div_q > DIV_MIN) begin
          div_d  = div_q - 5'd1;
          wren_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;

endmodule

// File: tb/tb_led_div_ctrl.sv
module tb_led_div_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam int INIT = 1;
  localparam int MINV = 0;
  localparam int MAXV = 31;

  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic [4:0] div_o;
  logic       wren_o;

  led_div_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HOLD),
    .REPEAT_CYC   (REP)
  ) dut (
    .clk100   (clk100),
    .rstn     (rstn),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .div_o    (div_o),
    .wren_o   (wren_o)
  );

  always #5 clk100 = ~clk100;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { int cyc; int div; } exp_t;
  exp_t exp_q[$];
  int   seen_q[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the raw samples taken at each edge since reset release:
  // a level is accepted once the last DEB synchronised samples all differ
  // from the accepted level; events come from the time since the press.
  bit hq_up[$];
  bit hq_dn[$];
  bit mdb[2];
  bit pend[2];
  int mpress[2];
  int mdiv = INIT;
  int n = 0;
  bit flip, old;
  int kk;

  function automatic bit raw_at(int b, int k);
    if (k < 1) return 1'b0;
    return (b == 0) ? hq_up[k-1] : hq_dn[k-1];
  endfunction

  initial forever begin
    @(posedge clk100);
    cyc++;
    if (!rstn) begin
      hq_up.delete();
      hq_dn.delete();
      n = 0;
      mdb[0] = 0; mdb[1] = 0;
      pend[0] = 0; pend[1] = 0;
      mdiv = INIT;
    end else begin
      n++;
      if (pend[0] && !pend[1] && mdiv < MAXV) begin
        mdiv++;
        exp_q.push_back('{cyc, mdiv});
      end else if (pend[1] && !pend[0] && mdiv > MINV) begin
        mdiv--;
        exp_q.push_back('{cyc, mdiv});
      end
      hq_up.push_back(btn_up_i);
      hq_dn.push_back(btn_dn_i);
      for (int b = 0; b < 2; b++) begin
        old  = mdb[b];
        flip = 1'b1;
        for (int j = n - DEB - 1; j <= n - 2; j++)
          if (raw_at(b, j) == old) flip = 1'b0;
        if (flip) mdb[b] = !old;
        pend[b] = 1'b0;
        if (mdb[b] && !old) begin
          pend[b]   = 1'b1;
          mpress[b] = n;
        end else if (mdb[b] && REP > 0) begin
          kk = n - mpress[b];
          if (kk == HOLD || (kk > HOLD && (kk - HOLD) % REP == 0)) pend[b] = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t e;
  always @(negedge clk100) begin
    if (rstn && wren_o) begin
      seen_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got div=%0d at cycle %0d expected no strobe", div_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_div", int'(div_o), e.div);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int k);
    repeat (k) @(posedge clk100);
    #2;
  endtask

  task automatic do_reset(int k);
    rstn = 1'b0;
    tick(k);
    rstn = 1'b1;
  endtask

  task automatic drained(string nm);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  int t0, rel, r, len;
  int rep_edges[7] = '{7, 17, 22, 27, 32, 37, 42};

  initial begin
    // 1: reset state
    tick(3);
    chk("reset_div", int'(div_o), INIT);
    chk("reset_wren", int'(wren_o), 0);
    rstn = 1'b1;
    seen_q.delete();
    tick(8);
    chk("idle_div", int'(div_o), INIT);
    chk("idle_strobes", seen_q.size(), 0);

    // 2: single press, one strobe at +7
    seen_q.delete();
    t0 = cyc;
    btn_up_i = 1'b1; tick(8); btn_up_i = 1'b0; tick(25);
    chk("press_strobes", seen_q.size(), 1);
    if (seen_q.size() > 0) chk("press_edge", seen_q[0] - t0, DEB + 3);
    chk("press_div", int'(div_o), 2);
    drained("press");

    // 3: glitch shorter than the debounce window
    do_reset(2); tick(2);
    seen_q.delete();
    btn_up_i = 1'b1; tick(3); btn_up_i = 1'b0; tick(20);
    chk("glitch_strobes", seen_q.size(), 0);
    chk("glitch_div", int'(div_o), 1);

    // 4: lower and upper saturation
    seen_q.delete();
    btn_dn_i = 1'b1; tick(6); btn_dn_i = 1'b0; tick(20);
    chk("dn1_strobes", seen_q.size(), 1);
    chk("dn1_div", int'(div_o), 0);
    seen_q.delete();
    btn_dn_i = 1'b1; tick(6); btn_dn_i = 1'b0; tick(20);
    chk("dn_sat_strobes", seen_q.size(), 0);
    chk("dn_sat_div", int'(div_o), 0);
    btn_up_i = 1'b1; tick(220); btn_up_i = 1'b0; tick(20);
    chk("to_max_div", int'(div_o), 31);
    seen_q.delete();
    btn_up_i = 1'b1; tick(6); btn_up_i = 1'b0; tick(20);
    chk("up_sat_strobes", seen_q.size(), 0);
    chk("up_sat_div", int'(div_o), 31);
    drained("sat");

    // 5: auto-repeat while held
    do_reset(2); tick(2);
    seen_q.delete();
    t0 = cyc;
    btn_up_i = 1'b1; tick(40); btn_up_i = 1'b0; tick(30);
    chk("repeat_count", seen_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < seen_q.size()) chk("repeat_edge", seen_q[i] - t0, rep_edges[i]);
    chk("repeat_div", int'(div_o), 8);
    drained("repeat");

    // 6a: both buttons together cancel
    seen_q.delete();
    btn_up_i = 1'b1; btn_dn_i = 1'b1; tick(8);
    btn_up_i = 1'b0; btn_dn_i = 1'b0; tick(20);
    chk("both_strobes", seen_q.size(), 0);
    chk("both_div", int'(div_o), 8);

    // 6b: reset in the middle of a hold (between strobes at +7 and +17)
    btn_up_i = 1'b1; tick(12);
    rstn = 1'b0; #1;
    chk("midrst_div", int'(div_o), INIT);
    chk("midrst_wren", int'(wren_o), 0);
    tick(2);
    rstn = 1'b1;
    rel = cyc;
    seen_q.delete();
    tick(9);
    chk("rerelease_strobes", seen_q.size(), 1);
    if (seen_q.size() > 0) chk("rerelease_edge", seen_q[0] - rel, DEB + 3);
    chk("rerelease_div", int'(div_o), 2);
    btn_up_i = 1'b0; tick(25);
    drained("midrst");

    // random segments against the model
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 5);
      len = $urandom_range(1, 30);
      btn_up_i = (r == 1 || r == 3);
      btn_dn_i = (r == 2 || r == 3 || r == 4);
      tick(len);
    end
    btn_up_i = 1'b0; btn_dn_i = 1'b0;
    tick(40);
    chk("random_div", int'(div_o), mdiv);
    drained("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
